// File: rtl/mem_dump_unit.sv
`default_nettype none
// ============================================================================
// Module      : mem_dump_unit
// Description : Streams a fixed-length region of data memory out through a
//               byte-wide UART transmitter.
//               Frame format: header 0xA5, DUMP_BYTES data bytes read from
//               address 0 upward, then one checksum byte.
//               The checksum is the XOR of all data bytes.
//               One memory read is issued per byte. The next read waits until
//               the transmitter has reported that the previous byte is fully
//               sent.
// Ports       : clk         - system clock, rising edge
//               rst         - asynchronous active-high reset
//               i_start     - dump request, only sampled while idle
//               i_abort     - drop the current dump and return to idle
//               o_busy      - high whenever not idle
//               o_done      - one-cycle pulse when a frame has completed
//               o_mem_addr  - data-memory byte address
//               o_mem_rd    - data-memory read strobe
//               i_mem_data  - read data, valid one cycle after o_mem_rd
//               o_tx_start  - one-cycle request to the UART transmitter
//               o_tx_data   - byte to transmit, held until i_tx_done
//               i_tx_done   - one-cycle pulse, byte fully sent
// Revision    : 1.0 - initial release
// ============================================================================
module mem_dump_unit #(
  parameter int ADDR_WIDTH = 7,
  parameter int DUMP_BYTES = 128
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic                  i_abort,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic                  o_mem_rd,
  input  logic [7:0]            i_mem_data,
  output logic                  o_tx_start,
  output logic [7:0]            o_tx_data,
  input  logic                  i_tx_done
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_SEND_HDR = 4'd1,
    S_WAIT_HDR = 4'd2,
    S_READ     = 4'd3,
    S_LATCH    = 4'd4,
    S_SEND     = 4'd5,
    S_WAIT_TX  = 4'd6,
    S_SEND_CHK = 4'd7,
    S_WAIT_CHK = 4'd8,
    S_FINISH   = 4'd9
  } state_t;

  localparam logic [7:0]            HDR_BYTE  = 8'hA5;
  // Address of the final data byte. With DUMP_BYTES = 2**ADDR_WIDTH this is
  // all-ones, so the counter stops there and never wraps.
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DUMP_BYTES - 1);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q,   cnt_d;
  logic [7:0]            chk_q,   chk_d;
  logic [7:0]            txd_q,   txd_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      chk_q   <= '0;
      txd_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      chk_q   <= chk_d;
      txd_q   <= txd_d;
    end
  end

  // Outputs depend only on the current state.
  // They therefore drop to zero the moment reset forces the state to IDLE.
  always_comb begin
    o_busy     = (state_q != S_IDLE);
    o_done     = (state_q == S_FINISH);
    o_mem_rd   = (state_q == S_READ);
    o_tx_start = (state_q == S_SEND_HDR) || (state_q == S_SEND) ||
                 (state_q == S_SEND_CHK);
    o_mem_addr = cnt_q;
    o_tx_data  = txd_q;
  end

  // Next-state logic.
  // txd_q is loaded with each byte as that byte's send state is entered.
  // This keeps o_tx_data stable from o_tx_start until i_tx_done.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    chk_d   = chk_q;
    txd_d   = txd_q;

    if (i_abort) begin
      // Abort outranks every other input and suppresses the o_done pulse.
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (i_start) begin
            state_d = S_SEND_HDR;
            cnt_d   = '0;
            chk_d   = '0;
            txd_d   = HDR_BYTE;
          end
        end
        S_SEND_HDR: state_d = S_WAIT_HDR;
        S_WAIT_HDR: if (i_tx_done) state_d = S_READ;
        S_READ:     state_d = S_LATCH;
        S_LATCH: begin
          txd_d   = i_mem_data;
          chk_d   = chk_q ^ i_mem_data;
          state_d = S_SEND;
        end
        S_SEND: state_d = S_WAIT_TX;
        S_WAIT_TX: begin
          if (i_tx_done) begin
            if (cnt_q == LAST_ADDR) begin
              txd_d   = chk_q;
              state_d = S_SEND_CHK;
            end else begin
              cnt_d   = cnt_q + ADDR_WIDTH'(1);
              state_d = S_READ;
            end
          end
        end
        S_SEND_CHK: state_d = S_WAIT_CHK;
        S_WAIT_CHK: if (i_tx_done) state_d = S_FINISH;
        S_FINISH:   state_d = S_IDLE;
        default:    state_d = S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_dump_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_dump_unit
// Description : Scoreboard bench for mem_dump_unit (ADDR_WIDTH=2, DUMP_BYTES=4).
//               Expected tx bytes and read addresses are queued when a dump
//               is launched. They are popped as the DUT produces them.
//               The UART is modelled as a responder that returns i_tx_done
//               10 cycles after each o_tx_start.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_dump_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_start, i_abort;
  logic       o_busy, o_done, o_mem_rd, o_tx_start;
  logic [1:0] o_mem_addr;
  logic [7:0] i_mem_data, o_tx_data;
  logic       i_tx_done;
  logic       resp_done = 1'b0;
  logic       spur_done = 1'b0;

  assign i_tx_done = resp_done | spur_done;

  always #5 clk = ~clk;

  mem_dump_unit #(.ADDR_WIDTH(2), .DUMP_BYTES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_start   (i_start),
    .i_abort   (i_abort),
    .o_busy    (o_busy),
    .o_done    (o_done),
    .o_mem_addr(o_mem_addr),
    .o_mem_rd  (o_mem_rd),
    .i_mem_data(i_mem_data),
    .o_tx_start(o_tx_start),
    .o_tx_data (o_tx_data),
    .i_tx_done (i_tx_done)
  );

  logic [7:0] mem [4] = '{8'hAA, 8'hBB, 8'hCD, 8'hEF};

  // Read data appears one cycle after the strobe. Otherwise it is random,
  // so latching on the wrong cycle shows up as a wrong byte.
  always @(posedge clk) begin
    if (o_mem_rd) i_mem_data <= mem[o_mem_addr];
    else          i_mem_data <= 8'($urandom);
  end

  int n_total = 0;
  int n_bad   = 0;
  int tx_cnt  = 0;
  int done_cnt = 0;
  int tx_cd   = 0;
  logic [7:0] hold_byte = 8'h00;
  logic [7:0] exp_q [$];
  logic [1:0] rd_q  [$];

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Monitor and UART responder in one process so their order is fixed.
  always @(negedge clk) begin
    if (o_busy && tx_cd > 0 && !o_tx_start)
      check_val("tx_hold", o_tx_data, hold_byte);
    if (o_tx_start) begin
      tx_cnt++;
      if (exp_q.size() == 0) check_val("tx_unexpected", 1, 0);
      else                   check_val("tx_byte", o_tx_data, exp_q.pop_front());
    end
    if (o_mem_rd) begin
      if (rd_q.size() == 0) check_val("rd_unexpected", 1, 0);
      else                  check_val("rd_addr", o_mem_addr, rd_q.pop_front());
      // The tx_done from the previous byte was the input at the edge just passed.
      check_val("rd_after_done", resp_done, 1);
    end
    if (o_done) done_cnt++;
    resp_done = 1'b0;
    if (tx_cd > 0) begin
      tx_cd--;
      if (tx_cd == 0) resp_done = 1'b1;
    end
    if (o_tx_start) begin
      tx_cd     = 10;
      hold_byte = o_tx_data;
    end
  end

  task automatic push_frame();
    exp_q.push_back(8'hA5);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(mem[i]);
      rd_q.push_back(2'(i));
    end
    exp_q.push_back(8'h33);
  endtask

  task automatic pulse_start();
    @(negedge clk); i_start = 1'b1;
    @(negedge clk); i_start = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int d0 = done_cnt;
    int k = 0;
    while (done_cnt == d0 && k < bound) begin
      @(negedge clk); #1; k++;
    end
    check_val("done_seen", 32'(done_cnt != d0), 1);
  endtask

  task automatic wait_tx(input int target);
    int k = 0;
    while (tx_cnt < target && k < 300) begin
      @(negedge clk); #1; k++;
    end
    check_val("tx_reached", 32'(tx_cnt >= target), 1);
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_busy"},  o_busy, 0);
    check_val({tag, "_done"},  o_done, 0);
    check_val({tag, "_rd"},    o_mem_rd, 0);
    check_val({tag, "_start"}, o_tx_start, 0);
    check_val({tag, "_addr"},  o_mem_addr, 0);
    check_val({tag, "_data"},  o_tx_data, 0);
  endtask

  initial begin
    int t0, d0;
    rst = 1'b1; i_start = 1'b0; i_abort = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Basic dump
    t0 = tx_cnt; d0 = done_cnt;
    push_frame();
    pulse_start();
    wait_done(400);
    check_val("basic_tx_count", tx_cnt - t0, 6);
    check_val("basic_done_count", done_cnt - d0, 1);
    check_val("basic_q_empty", exp_q.size() + rd_q.size(), 0);
    @(negedge clk); #1;
    check_val("basic_idle_busy", o_busy, 0);
    check_val("basic_single_done", done_cnt - d0, 1);

    // Spurious i_start while busy and i_tx_done during READ/LATCH
    repeat (5) @(negedge clk);
    t0 = tx_cnt; d0 = done_cnt;
    push_frame();
    fork
      begin
        pulse_start();
        wait_done(400);
      end
      begin
        repeat (3) @(negedge clk);
        i_start = 1'b1;
        @(negedge clk); i_start = 1'b0;
        for (int k = 0; k < 200; k++) begin
          @(negedge clk);
          if (o_mem_rd) break;
        end
        spur_done = 1'b1;
        @(negedge clk);
        @(negedge clk); spur_done = 1'b0;
      end
    join
    check_val("spur_tx_count", tx_cnt - t0, 6);
    check_val("spur_done_count", done_cnt - d0, 1);
    check_val("spur_q_empty", exp_q.size() + rd_q.size(), 0);

    // Abort during WAIT_TX of the first data byte
    repeat (5) @(negedge clk);
    t0 = tx_cnt; d0 = done_cnt;
    exp_q.push_back(8'hA5); exp_q.push_back(8'hAA); rd_q.push_back(2'd0);
    pulse_start();
    wait_tx(t0 + 2);
    @(negedge clk); i_abort = 1'b1;
    @(negedge clk); i_abort = 1'b0; #1;
    check_val("abort_busy", o_busy, 0);
    check_val("abort_txstart", o_tx_start, 0);
    repeat (40) @(negedge clk);
    check_val("abort_no_tx", tx_cnt - t0, 2);
    check_val("abort_no_done", done_cnt - d0, 0);
    // Restart after abort must begin with the header
    t0 = tx_cnt; d0 = done_cnt;
    push_frame();
    pulse_start();
    wait_done(400);
    check_val("restart_tx_count", tx_cnt - t0, 6);
    check_val("restart_q_empty", exp_q.size() + rd_q.size(), 0);

    // Asynchronous reset in SEND of the second data byte
    repeat (5) @(negedge clk);
    t0 = tx_cnt; d0 = done_cnt;
    exp_q.push_back(8'hA5); exp_q.push_back(8'hAA); exp_q.push_back(8'hBB);
    rd_q.push_back(2'd0); rd_q.push_back(2'd1);
    pulse_start();
    wait_tx(t0 + 3);
    #1 rst = 1'b1;
    #1 check_all_zero("async_rst");
    @(negedge clk); rst = 1'b0;
    repeat (30) @(negedge clk);
    check_val("rst_no_tx", tx_cnt - t0, 3);
    check_val("rst_no_done", done_cnt - d0, 0);
    check_val("rst_q_empty", exp_q.size() + rd_q.size(), 0);
    t0 = tx_cnt;
    push_frame();
    pulse_start();
    wait_done(400);
    check_val("post_rst_tx_count", tx_cnt - t0, 6);

    // Back-to-back full-range dumps
    repeat (5) @(negedge clk);
    t0 = tx_cnt; d0 = done_cnt;
    push_frame();
    push_frame();
    pulse_start();
    wait_done(400);
    @(negedge clk); i_start = 1'b1;
    @(negedge clk); i_start = 1'b0; #1;
    check_val("b2b_hdr_immediate", o_tx_start, 1);
    wait_done(400);
    check_val("b2b_tx_count", tx_cnt - t0, 12);
    check_val("b2b_done_count", done_cnt - d0, 2);
    check_val("b2b_q_empty", exp_q.size() + rd_q.size(), 0);
    repeat (20) @(negedge clk);
    check_val("b2b_no_wrap", tx_cnt - t0, 12);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_dump_unit.md
MEM_DUMP_UNIT -- requirements
Module: mem_dump_unit

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 7, meaning data-memory byte-address width.
REQ-002 SHALL have parameter DUMP_BYTES, default 128, meaning the number of bytes dumped per run (1..2^ADDR_WIDTH).
REQ-003 SHALL have port clk  input  1  system clock; all state changes on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port i_start  input  1  dump request, sampled in IDLE only.
REQ-006 SHALL have port i_abort  input  1  terminates the dump from any state.
REQ-007 SHALL have port o_busy  output  1  high in every state except IDLE.
REQ-008 SHALL have port o_done  output  1  one-cycle pulse marking dump completion.
REQ-009 SHALL have port o_mem_addr  output  ADDR_WIDTH  data-memory byte read address.
REQ-010 SHALL have port o_mem_rd  output  1  data-memory read strobe.
REQ-011 SHALL have port i_mem_data  input  8  read byte, valid exactly one cycle after o_mem_rd.
REQ-012 SHALL have port o_tx_start  output  1  one-cycle pulse to the UART transmitter.
REQ-013 SHALL have port o_tx_data  output  8  byte to transmit.
REQ-014 SHALL have port i_tx_done  input  1  one-cycle pulse from the UART transmitter, byte fully sent.

Function
REQ-015 SHALL frame each dump as header byte 0xA5, then DUMP_BYTES data bytes from address 0 ascending, then one checksum byte equal to the XOR of all data bytes.
REQ-016 SHALL implement states IDLE, SEND_HDR, WAIT_HDR, READ, LATCH, SEND, WAIT_TX, SEND_CHK, WAIT_CHK and FINISH.
REQ-017 SHALL go IDLE->SEND_HDR on i_start=1, clearing the address counter and the checksum to 0 on that edge.
REQ-018 SHALL assert o_tx_start for one cycle in SEND_HDR with o_tx_data=0xA5, then enter WAIT_HDR.
REQ-019 SHALL stay in WAIT_HDR until i_tx_done=1, then enter READ.
REQ-020 SHALL assert o_mem_rd for one cycle in READ with o_mem_addr equal to the counter, then enter LATCH.
REQ-021 SHALL in LATCH load i_mem_data into the tx data register, XOR it into the checksum, then enter SEND.
REQ-022 SHALL assert o_tx_start for one cycle in SEND, then enter WAIT_TX.
REQ-023 SHALL on i_tx_done in WAIT_TX enter SEND_CHK if the counter equals DUMP_BYTES-1; otherwise it SHALL increment the counter and enter READ.
REQ-024 SHALL assert o_tx_start in SEND_CHK with o_tx_data equal to the checksum, then enter WAIT_CHK, and SHALL enter FINISH on i_tx_done.
REQ-025 SHALL assert o_done for exactly the one FINISH cycle, then return to IDLE.
REQ-026 SHALL hold o_tx_data stable from each o_tx_start pulse until the matching i_tx_done.
REQ-027 SHALL ignore i_tx_done outside the WAIT_HDR, WAIT_TX and WAIT_CHK states.
REQ-028 SHALL ignore i_start while o_busy=1.
REQ-029 SHALL on i_abort=1 enter IDLE on the next edge from any state, without an o_done pulse, and i_abort SHALL take priority over i_start and i_tx_done.
REQ-030 SHALL use a counter exactly ADDR_WIDTH bits wide; with DUMP_BYTES=2^ADDR_WIDTH it SHALL terminate at address all-ones without wrapping.
REQ-031 SHALL keep o_mem_rd, o_tx_start and o_done low in every state other than those above.
REQ-032 SHALL run back-to-back dumps, accepting i_start in the IDLE cycle that immediately follows FINISH.

Reset
REQ-033 SHALL on rst=1, regardless of clk, force IDLE and set o_busy, o_done, o_mem_rd, o_tx_start, o_mem_addr, o_tx_data, the counter and the checksum to 0.
REQ-034 SHALL when rst is asserted mid-dump emit no further o_tx_start or o_done pulses, and a new dump after rst deasserts SHALL restart from the header.

Verification
REQ-035 SHALL verify a basic dump: DUMP_BYTES=4, memory[0..3]=AA,BB,CD,EF, i_start pulse, tx_done returned 10 cycles after each tx_start -> tx bytes A5,AA,BB,CD,EF,33, with o_done pulsed once after the final tx_done.
REQ-036 SHALL verify read timing: o_mem_rd is observed with addr 0,1,2,3 in order, each exactly one cycle before LATCH, and each read follows the previous byte's tx_done.
REQ-037 SHALL verify abort: i_abort during WAIT_TX of byte 1 -> IDLE next cycle, o_busy=0, no o_done and no further tx_start; a subsequent i_start restarts with 0xA5.
REQ-038 SHALL verify spurious inputs: i_start pulsed during busy and i_tx_done pulsed in READ/LATCH -> byte sequence and counts unchanged from the basic dump.
REQ-039 SHALL verify async reset: rst asserted between clock edges in SEND -> all outputs 0 immediately, before the next clk edge.
REQ-040 SHALL verify a full-range dump: ADDR_WIDTH=2, DUMP_BYTES=4, back-to-back i_start right after o_done -> two identical 6-byte frames with the last address 3 and no wrap.
